div_tick_scanner: RTL

//   Downstream consumer of the 18-bit ripple frequency divider output bus.
//   - Selects one divider tap and synchronises it into the clk domain.
//   - Turns each rising edge of that tap into a one-cycle tick.
//   - Uses the tick to scan a 4-digit, active-low, common-anode 7-segment display.
//   - Inserts a blanking gap between digits to prevent ghosting.

---
 rtl/div_tick_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div_tick_scanner.sv
// div_tick_scanner: picks one tap of the ripple divider bus, synchronises it
// into clk, turns its rising edges into one-cycle ticks and uses those ticks
// to scan a 4-digit active-low common-anode 7-segment display, with a blanking
// gap between digits to suppress ghosting.
//
// state | meaning
// ------+------------------------------------------------------------
// OFF   | display dark, digit index parked at 0
// BLANK | all anodes off, counting out the inter-digit gap
// SHOW  | one anode low, segments hold the nibble latched on entry
module div_tick_scanner #(
  parameter int BLANK_CYCLES = 4,
  parameter int NUM_TAPS     = 18
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_TAPS-1:0] div_in,
  input  logic [4:0]          sel,
  input  logic                en,
  input  logic [15:0]         digits,
  output logic                tick,
  output logic [1:0]          digit_idx,
  output logic [3:0]          anode,
  output logic [6:0]          seg
);

  localparam logic [4:0] SEL_MAX  = 5'(NUM_TAPS - 1);
  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] sel_q;
  logic [4:0] sel_c;
  logic       tap;
  logic       s1, s2, s3;
  logic [3:0] nib_cur;

  // active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // clamp the tap index and pick the tap and the pending digit nibble
  always_comb begin
    sel_c = (sel > SEL_MAX) ? SEL_MAX : sel;
    tap   = div_in[sel_c];
    case (digit_idx)
      2'd0:    nib_cur = digits[3:0];
      2'd1:    nib_cur = digits[7:4];
      2'd2:    nib_cur = digits[11:8];
      default: nib_cur = digits[15:12];
    endcase
  end

  // tap synchroniser and rising-edge detect; a select change preloads the
  // whole chain with the new tap so the switch itself never looks like an edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      tick  <= 1'b0;
      sel_q <= '0;
    end else begin
      sel_q <= sel;
      if (sel != sel_q) begin
        s1   <= tap;
        s2   <= tap;
        s3   <= tap;
        tick <= 1'b0;
      end else begin
        s1   <= tap;
        s2   <= s1;
        s3   <= s2;
        tick <= s2 & ~s3;
      end
    end
  end

  // display scan FSM with registered outputs; ticks seen in BLANK are dropped
  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      state     <= ST_OFF;
      cnt       <= '0;
      digit_idx <= 2'd0;
      anode     <= 4'b1111;
      seg       <= 7'h7F;
    end else begin
      case (state)
        ST_OFF: begin
          state     <= ST_BLANK;
          cnt       <= '0;
          digit_idx <= 2'd0;
          anode     <= 4'b1111;
          seg       <= 7'h7F;
        end
        ST_BLANK: begin
          anode <= 4'b1111;
          seg   <= 7'h7F;
          if (cnt == CNT_LAST) begin
            state <= ST_SHOW;
            anode <= ~(4'b0001 << digit_idx);
            seg   <= hex7(nib_cur);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SHOW: begin
          if (tick) begin
            state     <= ST_BLANK;
            cnt       <= '0;
            digit_idx <= digit_idx + 2'd1;
            anode     <= 4'b1111;
            seg       <= 7'h7F;
          end
        end
        default: begin
          state     <= ST_OFF;
          cnt       <= '0;
          digit_idx <= 2'd0;
          anode     <= 4'b1111;
          seg       <= 7'h7F;
        end
      endcase
    end
  end

endmodule
